fetch_aligner: RTL

FETCH_ALIGNER -- requirements
Module: fetch_aligner

---
 rtl/fetch_aligner.sv | 136 +++++++++++++
 1 files changed

// File: rtl/fetch_aligner.sv
// Instruction fetch aligner: turns a stream of word-aligned 32-bit fetches into
// a stream of 16/32-bit RISC-V instructions, buffering a residual halfword.
module fetch_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] fetch_addr,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_data,
    output logic        fetch_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_is_c,
    input  logic        instr_ready
);

    localparam logic [31:0] RESET_NEXT_PC  = RESET_PC & ~32'd1;
    localparam logic [31:0] RESET_FETCH_PC = RESET_PC & ~32'd3;
    localparam logic        RESET_SKIP_LOW = RESET_PC[1];

    function automatic logic is_compressed(input logic [15:0] hw);
        return hw[1:0] != 2'b11;
    endfunction

    logic [15:0] res_q, res_d;
    logic        res_valid_q, res_valid_d;
    logic        skip_low_q, skip_low_d;
    logic [31:0] next_pc_q, next_pc_d;
    logic [31:0] fetch_addr_q, fetch_addr_d;
    logic        instr_valid_q, instr_valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        instr_is_c_q, instr_is_c_d;

    logic advance;
    logic res_is_c;
    logic fire;

    assign advance     = !instr_valid_q || instr_ready;
    assign res_is_c    = res_valid_q && is_compressed(res_q);
    assign fetch_ready = advance && !redirect_valid && !res_is_c;
    assign fire        = fetch_valid && fetch_ready;

    always_comb begin
        res_d         = res_q;
        res_valid_d   = res_valid_q;
        skip_low_d    = skip_low_q;
        next_pc_d     = next_pc_q;
        fetch_addr_d  = fetch_addr_q;
        instr_valid_d = instr_valid_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_is_c_d  = instr_is_c_q;

        if (redirect_valid) begin
            // Redirect wins over everything, including a stalled output.
            instr_valid_d = 1'b0;
            res_valid_d   = 1'b0;
            next_pc_d     = redirect_pc & ~32'd1;
            fetch_addr_d  = redirect_pc & ~32'd3;
            skip_low_d    = redirect_pc[1];
        end else if (advance) begin
            instr_valid_d = 1'b0;
            if (res_is_c) begin
                instr_valid_d = 1'b1;
                instr_d       = {16'h0000, res_q};
                instr_pc_d    = next_pc_q;
                instr_is_c_d  = 1'b1;
                res_valid_d   = 1'b0;
                next_pc_d     = next_pc_q + 32'd2;
            end else if (fire) begin
                fetch_addr_d = fetch_addr_q + 32'd4;
                res_d        = fetch_data[31:16];
                if (skip_low_q) begin
                    // Redirect landed on the upper halfword: drop the low half.
                    res_valid_d = 1'b1;
                    skip_low_d  = 1'b0;
                end else if (res_valid_q) begin
                    instr_valid_d = 1'b1;
                    instr_d       = {fetch_data[15:0], res_q};
                    instr_pc_d    = next_pc_q;
                    instr_is_c_d  = 1'b0;
                    next_pc_d     = next_pc_q + 32'd4;
                end else if (is_compressed(fetch_data[15:0])) begin
                    instr_valid_d = 1'b1;
                    instr_d       = {16'h0000, fetch_data[15:0]};
                    instr_pc_d    = next_pc_q;
                    instr_is_c_d  = 1'b1;
                    res_valid_d   = 1'b1;
                    next_pc_d     = next_pc_q + 32'd2;
                end else begin
                    instr_valid_d = 1'b1;
                    instr_d       = fetch_data;
                    instr_pc_d    = next_pc_q;
                    instr_is_c_d  = 1'b0;
                    next_pc_d     = next_pc_q + 32'd4;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_q         <= 16'h0000;
            res_valid_q   <= 1'b0;
            skip_low_q    <= RESET_SKIP_LOW;
            next_pc_q     <= RESET_NEXT_PC;
            fetch_addr_q  <= RESET_FETCH_PC;
            instr_valid_q <= 1'b0;
            instr_q       <= 32'h0000_0000;
            instr_pc_q    <= 32'h0000_0000;
            instr_is_c_q  <= 1'b0;
        end else begin
            res_q         <= res_d;
            res_valid_q   <= res_valid_d;
            skip_low_q    <= skip_low_d;
            next_pc_q     <= next_pc_d;
            fetch_addr_q  <= fetch_addr_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_is_c_q  <= instr_is_c_d;
        end
    end

    assign fetch_addr  = fetch_addr_q;
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_is_c  = instr_is_c_q;

endmodule
